tx_gearbox66: RTL
=================

TX_GEARBOX66 -- requirements
Module: tx_gearbox66

Interface
REQ-001: Port clk_i, input, 1 -- system clock; all state updates on its rising edge.
REQ-002: Port rst_i, input, 1 -- reset, synchronous, active-high.
REQ-003: Port blk_data_i, input, 64 -- 66b block payload.
REQ-004: Port blk_hdr_i, input, 2 -- 66b block sync header; legal values 2'b01 (data), 2'b10 (cmd).
REQ-005: Port blk_valid_i, input, 1 -- block offered this cycle.
REQ-006: Port blk_ready_o, output, 1 -- block accepted this cycle when blk_valid_i and blk_ready_o are both high.
REQ-007: Port word_o, output, 32 -- serial word; bit 31 is transmitted first.
REQ-008: Port word_valid_o, output, 1 -- word_o holds a valid word.
REQ-009: Port word_ready_i, input, 1 -- downstream consumes word_o when word_valid_o and word_ready_i are both high.
REQ-010: Port gbox_cnt_o, output, 6 -- word phase index within a 33-word / 16-block frame.
REQ-011: Port hdr_err_o, output, 1 -- one-cycle pulse when an accepted block has an illegal header.

Function
REQ-012: The block shall contain a 128-bit shift buffer, MSB-aligned, whose valid bits occupy buffer[127 -: fill].
REQ-013: The block shall keep a fill counter of 8 bits, range 0..128.
REQ-014: Accepted block bit order shall be {blk_hdr_i, blk_data_i}; blk_hdr_i[1] is transmitted first.
REQ-015: blk_ready_o shall be high iff fill <= 62; it is a function of registered state only, with no combinational path from any input.
REQ-016: The output stage may load ("load") iff (!word_valid_o || word_ready_i) and fill >= 32.
REQ-017: On load: word_o <= buffer[127:96]; word_valid_o <= 1; buffer shifts left by 32; fill -= 32.
REQ-018: If the output stage is free but fill < 32: word_valid_o <= 0 and word_o holds its value.
REQ-019: If word_valid_o = 1 and word_ready_i = 0, word_o and word_valid_o shall hold unchanged.
REQ-020: On accept, the 66 block bits shall be written at buffer[127 - F -: 66], where F is fill after any same-cycle load shift; fill = F + 66.
REQ-021: Simultaneous load and accept in one cycle shall both take effect; the new fill is fill - 32 + 66.
REQ-022: fill shall never exceed 128 and never underflow.
REQ-023: Latency: a block accepted in cycle N with fill = 0 shall have its first word on word_o in cycle N+2.
REQ-024: gbox_cnt_o shall increment on each load and wrap from 32 to 0; it shall not change otherwise.
REQ-025: hdr_err_o shall pulse in the cycle after accepting a block with blk_hdr_i of 2'b00 or 2'b11; the block is still transmitted unmodified.
REQ-026: With blk_valid_i held high and word_ready_i held high, word_valid_o shall stay high continuously after the first word; the steady state is 33 words per 16 blocks.

Reset
REQ-027: While rst_i = 1 at a clock edge, the next state shall be: fill = 0, buffer = 0, word_o = 0, word_valid_o = 0, gbox_cnt_o = 0, hdr_err_o = 0.
REQ-028: Consequently blk_ready_o = 1 in the first cycle after reset.
REQ-029: Reset mid-operation shall discard all buffered bits, including partial blocks, with no words emitted for them.
REQ-030: Handshakes presented during reset shall be ignored.

Verification
REQ-031: Single block (hdr 2'b01, data all ones), word_ready_i = 1 -> word_o = 0x7FFFFFFF in cycle N+2, then 0xFFFFFFFF; word_valid_o then drops with fill = 2; gbox_cnt_o = 2.
REQ-032: 16 back-to-back blocks, continuous word_ready_i -> exactly 33 consecutive valid words, bit-exact against the concatenated 1056-bit stream; gbox_cnt_o runs 0..32 and returns to 0.
REQ-033: word_ready_i low for 5 cycles mid-stream -> word_o held constant; blk_ready_o low once fill > 62; no bit lost or duplicated after release.
REQ-034: Block with hdr 2'b11 -> hdr_err_o = 1 for exactly one cycle; the header bits 11 appear in the output stream.
REQ-035: rst_i asserted with fill = 98 -> next cycle word_valid_o = 0, gbox_cnt_o = 0, blk_ready_o = 1; the next block's header is the first bit out.
REQ-036: Random valid/ready stimulus for 10k cycles -> output stream equals the input block stream, and fill stays within 0..128.

Source files
------------

// File: rtl/tx_gearbox66.sv
// tx_gearbox66: packs 66-bit blocks ({sync header, 64-bit payload}) into a
// stream of 32-bit words, MSB first. A 128-bit MSB-aligned shift buffer holds
// the pending bits; 16 blocks (1056 bits) drain as exactly 33 words.
//
// Handshake semantics (both sides): a transfer happens on a rising clock edge
// where valid and ready are both high. The producer may change or drop valid
// freely while no transfer has happened. blk_ready_o depends on registered
// state only. word_o/word_valid_o hold steady while a word is offered and
// word_ready_i is low.
module tx_gearbox66 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] blk_data_i,
  input  logic [1:0]  blk_hdr_i,
  input  logic        blk_valid_i,
  output logic        blk_ready_o,
  output logic [31:0] word_o,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  output logic [5:0]  gbox_cnt_o,
  output logic        hdr_err_o
);

  // Valid bits live in buf_q[127 -: fill_q]; all bits below that are zero.
  logic [127:0] buf_q, buf_d;
  logic [7:0]   fill_q, fill_d;
  logic [31:0]  word_q, word_d;
  logic         word_valid_q, word_valid_d;
  logic [5:0]   cnt_q, cnt_d;
  logic         hdr_err_q, hdr_err_d;

  logic         out_free;
  logic         load;
  logic         accept;
  logic [65:0]  blk_bits;
  logic [127:0] buf_shifted;
  logic [7:0]   fill_shifted;
  logic [127:0] blk_placed;
  logic [127:0] keep_mask;

  // A block always fits once fill <= 62: 62 + 66 = 128.
  assign blk_ready_o = (fill_q <= 8'd62);
  assign out_free    = !word_valid_q || word_ready_i;
  assign load        = out_free && (fill_q >= 8'd32);
  assign accept      = blk_valid_i && blk_ready_o;
  assign blk_bits    = {blk_hdr_i, blk_data_i};

  // Next-state: drain a word from the top, then append the accepted block
  // directly below whatever remains after that drain.
  always_comb begin
    buf_shifted  = load ? {buf_q[95:0], 32'd0} : buf_q;
    fill_shifted = load ? (fill_q - 8'd32) : fill_q;
    blk_placed   = {blk_bits, 62'd0} >> fill_shifted;
    keep_mask    = ~({128{1'b1}} >> fill_shifted);

    buf_d  = buf_shifted;
    fill_d = fill_shifted;
    if (accept) begin
      buf_d  = (buf_shifted & keep_mask) | blk_placed;
      fill_d = fill_shifted + 8'd66;
    end

    word_d       = word_q;
    word_valid_d = word_valid_q;
    cnt_d        = cnt_q;
    if (load) begin
      word_d       = buf_q[127:96];
      word_valid_d = 1'b1;
      cnt_d        = (cnt_q == 6'd32) ? 6'd0 : (cnt_q + 6'd1);
    end else if (out_free) begin
      word_valid_d = 1'b0;
    end

    hdr_err_d = accept && ((blk_hdr_i == 2'b00) || (blk_hdr_i == 2'b11));
  end

  // State registers; reset drops every buffered bit, including partial blocks.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_q        <= '0;
      fill_q       <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      cnt_q        <= '0;
      hdr_err_q    <= 1'b0;
    end else begin
      buf_q        <= buf_d;
      fill_q       <= fill_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      cnt_q        <= cnt_d;
      hdr_err_q    <= hdr_err_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = word_valid_q;
  assign gbox_cnt_o   = cnt_q;
  assign hdr_err_o    = hdr_err_q;

endmodule
